// File: rtl/csa_mp_sequencer.sv
// Multi-precision add/subtract sequencer: WORDS*32-bit operands are pushed
// limb by limb (LS first) through a single 32-bit carry-select adder.
module csa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    logic [16:0] lo;
    logic [16:0] hi0;
    logic [16:0] hi1;

    always_comb begin
        lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
        hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
        hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;
        // Upper half precomputed for both carries; low-half carry selects.
        {cout, sum[31:16]} = lo[16] ? hi1 : hi0;
        sum[15:0] = lo[15:0];
        overflow  = (a[31] == b[31]) && (sum[31] != a[31]);
    end
endmodule

module csa_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [32*WORDS-1:0]   a,
    input  logic [32*WORDS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  overflow
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [IDX_W+4:0]   limb_lsb;
    logic [31:0]        add_a, add_b, add_sum;
    logic               add_cout, add_ovf;

    always_comb begin
        limb_lsb = {idx_q, 5'b0};
        add_a    = a_q[limb_lsb +: 32];
        add_b    = b_q[limb_lsb +: 32] ^ {32{sub_q}};
    end

    csa32 u_csa (
        .a        (add_a),
        .b        (add_b),
        .cin      (carry_q),
        .sum      (add_sum),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[limb_lsb +: 32] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    // work_d already holds the final limb merged in
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    ovf_d   = add_ovf;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_csa_mp_sequencer.sv
// Scoreboard bench for csa_mp_sequencer (WORDS=4): directed vectors with
// hand-computed results, checked by a monitor on every done pulse.
module tb_csa_mp_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk, rst, start, sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    int n_cmp  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    csa_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", sum, e.s);
                check("cout", W'(cout), W'(e.c));
                check("overflow", W'(overflow), W'(e.o));
            end
        end
    end

    task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        a = av; b = bv; sub = sv; start = 1'b1;
        e.s = es; e.c = ec; e.o = eo;
        exp_q.push_back(e);
    endtask

    // Called right after drive_op; scrambles inputs after acceptance.
    task automatic wait_done(input string name);
        int cyc;
        bit seen;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        sub = ~sub;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({name, "_busy"}, W'(busy), W'(1));
            if (done) seen = 1;
        end
        check({name, "_latency"}, W'(cyc), W'(WORDS + 1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(overflow), W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Carry ripple across limbs
        drive_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
                 128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0);
        wait_done("ripple");
        @(negedge clk);
        // Positive overflow
        drive_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
                 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
        wait_done("pos_ovf");
        @(negedge clk);
        // 0 - 1
        drive_op(128'h0, 128'h1, 1'b1,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        wait_done("zero_minus_one");
        @(negedge clk);
        // Most negative - 1
        drive_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, 1'b1,
                 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        wait_done("neg_ovf");
        @(negedge clk);
        // Borrow through upper limbs
        drive_op(128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'h1, 1'b1,
                 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1'b1, 1'b0);
        wait_done("borrow");
        @(negedge clk);
        // Mixed pattern with carry between limbs 1 and 2
        drive_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                 128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0,
                 128'h1234_5678_9ABC_DF01_0FED_CBA9_8765_4321, 1'b0, 1'b0);
        wait_done("mixed");
        @(negedge clk);

        // -10 + -20, then back-to-back -999 + 999 issued in the DONE cycle
        drive_op(-128'sd10, -128'sd20, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE2, 1'b1, 1'b0);
        wait_done("neg_neg");
        drive_op(-128'sd999, 128'd999, 1'b0, 128'h0, 1'b1, 1'b0);
        wait_done("b2b");
        @(negedge clk);

        // start held through RUN with other operands: ignored
        drive_op(128'd5, 128'd3, 1'b0, 128'd8, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        a = 128'd100; b = 128'd200;
        repeat (3) @(negedge clk);
        start = 1'b0;
        begin
            int cyc;
            cyc = 3;
            while (!done && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("hold_start_latency", W'(cyc), W'(WORDS + 1));
        end
        @(negedge clk);
        check("hold_start_idle", W'(busy), W'(0));

        // Reset at limb 2: abort, no done, outputs cleared
        a = 128'hFFFF; b = 128'h1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_sum", sum, '0);
        check("abort_cout", W'(cout), W'(0));
        check("abort_ovf", W'(overflow), W'(0));
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // rst and start together: start not accepted
        rst = 1'b1; start = 1'b1; a = 128'd1; b = 128'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", W'(busy), W'(0));
        repeat (6) @(negedge clk);

        drive_op(128'd40, 128'd2, 1'b0, 128'd42, 1'b0, 1'b0);
        wait_done("after_abort");
        @(negedge clk);

        check("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/csa_mp_sequencer.md
Name: csa_mp_sequencer

Overview:
Multi-precision add/subtract sequencer built around one 32-bit CSA instance (a, b, cin -> sum, cout, overflow).
Splits WORDS*32-bit operands into 32-bit limbs and feeds them through the shared adder, least significant limb first, one limb per clock.
Chains the carry between limbs in a register.
Reports the full-width sum, carry-out and signed overflow with a start/busy/done handshake. Sits between the operand register file and the ALU result bus.

Parameters:
WORDS, 4, number of 32-bit limbs per operand (2..16); operand width W = 32*WORDS

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only when idle or done
sub  input  1  0 = a+b, 1 = a-b; latched on accepted start
a  input  W  operand A, two's complement; latched on accepted start
b  input  W  operand B, two's complement; latched on accepted start
busy  output  1  high while limbs are being processed (RUN)
done  output  1  one-cycle pulse: sum/cout/overflow valid and updated
sum  output  W  result; holds last completed value
cout  output  1  carry out of the top limb (for sub: 1 = no borrow)
overflow  output  1  signed overflow of the full-width operation

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, limb index=0, carry reg=0, operand latches=0.
- States:
  - IDLE: busy=0, done=0. start=1 -> latch a, b, sub; carry reg <= sub; index <= 0; go RUN. start=0 -> stay.
  - RUN: busy=1. Adder inputs per cycle:
    - adder.a = A[32*i+31:32*i]
    - adder.b = B limb XOR {32{sub}}
    - adder.cin = carry reg
  - RUN, each cycle: write adder.sum into working-register limb i; carry reg <= adder.cout; index++.
  - RUN, when i = WORDS-1: load the sum output from the working register (with the final limb merged in), cout <= adder.cout, overflow <= adder.overflow of the top limb; go DONE.
  - DONE: done=1 for exactly one cycle, busy=0. start=1 -> accept as in IDLE, go RUN (back-to-back, no bubble). Otherwise go IDLE.
- Latency: start accepted at edge 0; RUN occupies edges 1..WORDS; done is high in the cycle after edge WORDS. Throughput: one operation per WORDS+1 cycles.
- start in RUN is ignored: no latch, no queueing, no effect on the current operation.
- Changes to a, b or sub after acceptance have no effect. The bench may change them freely.
- sum, cout and overflow change only on the RUN->DONE transition. Partial limbs are never visible on sum.
- Overflow definition: (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is b after the conditional inversion. This equals the top-limb CSA overflow output.
- Width rules: all arithmetic is modulo 2^W; the limb index is ceil(log2(WORDS)) bits wide.
- rst during RUN: abort immediately. No done pulse; outputs return to reset values on that edge.
- rst and start in the same cycle: rst wins; start is not accepted.

Test Plan:
1. Carry ripple across limbs (WORDS=4): a=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x0000_0000_0000_0001_0000_0000_0000_0000, cout=0, overflow=0; done exactly 5 cycles after start.
2. Positive overflow: a=0x7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000_0000_0000_0000_0000, cout=0, overflow=1.
3. Subtract and negative overflow:
   - a=0, b=1, sub=1 -> sum=all F, cout=0, overflow=0.
   - a=0x8000_0…_0000, b=1, sub=1 -> sum=0x7FFF_F…_FFFF, cout=1, overflow=1.
4. Negative + negative: a=-10, b=-20 (128-bit) -> sum=0xFFFF_…_FFE2, cout=1, overflow=0.
   - Then a=-999, b=999 -> sum=0, cout=1, overflow=0.
5. Handshake:
   - start held high during RUN with different operands -> first result unchanged.
   - start asserted in the DONE cycle -> second op accepted with busy high the next cycle, its done 5 cycles later.
6. Reset mid-operation: rst=1 at RUN limb 2 -> next cycle busy=0, sum=0, cout=0, overflow=0, no done pulse. A subsequent start computes correctly.
